bus_distributor: RTL

- Registered 1-to-4 demultiplexer: accepts one 8-bit bus with a 4-bit one-hot destination select and delivers the byte to exactly one of four output channels.
- Each output channel is a single-entry register with a valid/ready handshake.
- Sits downstream of the ALU result path and steers results to four consumers (e.g. accumulator, register-file write port, flags/IO, debug tap).
- Illegal selects are dropped and counted.

---
 rtl/bus_distributor_pkg.sv | 35 +++
 rtl/bus_distributor_if.sv | 37 +++
 rtl/bus_distributor_dist_slot.sv | 51 +++++
 rtl/bus_distributor.sv | 85 ++++++++
 4 files changed

// File: rtl/bus_distributor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_distributor_pkg
//  Description : Shared constants and the one-hot select decoder used by the
//                distributor and by the ALU-side encoder logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_distributor_pkg;

    localparam int c_ONEHOT_W = 4;
    localparam int c_NUM_CH   = 4;

    // Decoded destination: legal is set only for exactly one bit high.
    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } sel_dec_t;

    // Zero or multi-hot selects report illegal with index 0.
    function automatic sel_dec_t onehot_decode(input logic [c_ONEHOT_W-1:0] sel);
        sel_dec_t r;
        r.legal = 1'b0;
        r.idx   = 2'd0;
        case (sel)
            4'b0001: begin r.legal = 1'b1; r.idx = 2'd0; end
            4'b0010: begin r.legal = 1'b1; r.idx = 2'd1; end
            4'b0100: begin r.legal = 1'b1; r.idx = 2'd2; end
            4'b1000: begin r.legal = 1'b1; r.idx = 2'd3; end
            default: begin r.legal = 1'b0; r.idx = 2'd0; end
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_distributor_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_distributor_if
//  Description : Producer-side input bus, four consumer channels and the
//                illegal-select error outputs of the distributor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_distributor_if #(
    parameter int W     = 8,
    parameter int ERR_W = 8
);
    import bus_distributor_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic [W-1:0]                   in_data;
    logic [c_ONEHOT_W-1:0]          in_sel;
    logic [c_NUM_CH-1:0]            out_valid;
    logic [c_NUM_CH-1:0]            out_ready;
    logic [c_NUM_CH*W-1:0]          out_data;
    logic                           err_pulse;
    logic [ERR_W-1:0]               err_count;

    // Distributor side.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, err_pulse, err_count
    );

    // Producer / consumer side.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, err_pulse, err_count
    );

endinterface
`default_nettype wire

// File: rtl/bus_distributor_dist_slot.sv
`default_nettype none
// ============================================================================
//  Module      : dist_slot
//  Description : Single-entry valid/ready holding register. Supports load,
//                drain and simultaneous load+drain without a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module dist_slot #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         load_i,
    input  wire logic [W-1:0] data_i,
    input  wire logic         ready_i,
    output logic              valid_o,
    output logic [W-1:0]      data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // Next state: a load wins (covers pass-through), otherwise drain on ready.
    // The top only loads when the slot is empty or being drained.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/bus_distributor.sv
`default_nettype none
// ============================================================================
//  Module      : bus_distributor
//  Description : Registered 1-to-4 demultiplexer. Legal one-hot selects load
//                one channel slot; illegal selects are dropped and counted.
//                in_ready depends combinationally on in_sel and out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_distributor
    import bus_distributor_pkg::*;
#(
    parameter int W     = 8,
    parameter int ERR_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    bus_distributor_if.slave    bus
);

    sel_dec_t                w_dec;
    logic                    w_tgt_busy;
    logic                    w_accept;
    logic                    w_drop;
    logic [c_NUM_CH-1:0]     w_load;
    logic [c_NUM_CH-1:0]     w_valid;
    logic [c_NUM_CH*W-1:0]   w_data;

    logic                    err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]        err_count_q, err_count_d;

    // Decode the destination select.
    always_comb begin
        w_dec = onehot_decode(bus.in_sel);
    end

    // Only a legal select whose slot is full and not draining stalls.
    assign w_tgt_busy   = w_valid[w_dec.idx] & ~bus.out_ready[w_dec.idx];
    assign bus.in_ready = rst_n & (~w_dec.legal | ~w_tgt_busy);
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_drop       = w_accept & ~w_dec.legal;

    generate
        for (genvar i = 0; i < c_NUM_CH; i++) begin : g_slot
            assign w_load[i] = w_accept & w_dec.legal & (w_dec.idx == 2'(i));

            dist_slot #(.W(W)) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (w_load[i]),
                .data_i  (bus.in_data),
                .ready_i (bus.out_ready[i]),
                .valid_o (w_valid[i]),
                .data_o  (w_data[i*W +: W])
            );
        end
    endgenerate

    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;

    // Error next state: pulse follows a dropped transfer, count saturates.
    always_comb begin
        err_pulse_d = w_drop;
        err_count_d = err_count_q;
        if (w_drop && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

    // Error state register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;

endmodule
`default_nettype wire
